dvp_frame_source: RTL and testbench
===================================

# dvp_frame_source

Synthesizable camera-side DVP (OV7670-style) source that drives `Pclk`, `Vsyn`, `Href` and `data` toward the `camara` capture block. It generates complete frames of RGB565 test pattern (colour bars or a counting ramp) with programmable blanking. It is used as an on-FPGA sensor stand-in, for bring-up without the physical camera, and as the stimulus model in capture-path benches.

## Interface

Parameters:
- `H_ACTIVE`, 640: active pixels per line; each pixel is 2 bytes, so `Href` is high for 2·H_ACTIVE Pclk periods. Must be a multiple of 8.
- `V_ACTIVE`, 480: active lines per frame.
- `H_BLANK`, 144: Pclk periods with `Href` low after each active line.
- `VS_LINES`, 3: line periods with `Vsyn` high.
- `V_BACK`, 17: blank line periods after VSYNC.
- `V_FRONT`, 10: blank line periods after the last active line.
- `PCLK_DIV`, 2: `clk` cycles per Pclk half-period, ≥1.

Ports:
- `clk` in 1: system clock.
- `rst` in 1: synchronous, active-high reset.
- `PWDN` in 1: power-down, active high; forces the idle state.
- `pattern_sel` in 1: 0 = colour bars, 1 = ramp. Sampled at frame start.
- `Pclk` out 1: pixel clock, registered.
- `Vsyn` out 1: vertical sync, active high.
- `Href` out 1: line valid, active high.
- `data` out 8: pixel byte.
- `frame_start` out 1: one-`clk` pulse when `Vsyn` rises.
- `frame_cnt` out 16: completed frames, wraps at 2^16.

## Operation

- Reset values: `Pclk`=0, `Vsyn`=0, `Href`=0, `data`=0, `frame_start`=0, `frame_cnt`=0, state IDLE.
- Pclk generator: divider counts 0..PCLK_DIV-1 and toggles `Pclk` at terminal count. A "tick" is the `clk` cycle where `Pclk` goes 1→0. All protocol state (`Vsyn`, `Href`, `data`, counters) updates only on ticks. Data is therefore stable across each rising edge.
- Line period: L = 2·H_ACTIVE + H_BLANK ticks. The column counter runs 0..L-1.
- FSM, advancing on ticks:
  - IDLE → VSYNC when `PWDN`=0.
  - VSYNC (`Vsyn`=1) for VS_LINES·L ticks → VBACK.
  - VBACK for V_BACK·L ticks → ACTIVE.
  - ACTIVE: V_ACTIVE lines. `Href`=1 for columns 0..2·H_ACTIVE-1, then 0 → VFRONT.
  - VFRONT for V_FRONT·L ticks → VSYNC. `frame_cnt`++ on this transition.
- `frame_start` pulses on the tick entering VSYNC. `pattern_sel` is latched on the same tick.
- Byte order: high byte first. Pixel p = column/2.
- Colour bars: bar = p / (H_ACTIVE/8), giving RGB565 values in order FFFF, FFE0, 07FF, 07E0, F81F, F800, 001F, 0000.
- Ramp: `data` = (column + line)[7:0], where line is the active-line index from 0.
- `data`=0 whenever `Href`=0.
- `PWDN`=1 in any state: on the next `clk`, state → IDLE, counters cleared, `Pclk`/`Vsyn`/`Href`/`data` forced 0, divider held. `frame_cnt` is not incremented for an aborted frame. On release, generation restarts from VSYNC with a full frame.
- `rst` mid-frame behaves identically, but also clears `frame_cnt`.

## Timing

- Pclk period = 2·PCLK_DIV `clk` cycles.
- First `Pclk` rise occurs PCLK_DIV `clk` cycles after `PWDN` is released.
- The first tick enters VSYNC.
- All outputs change only on tick cycles, except the forced-0 cases above.
- The first `Href` rise occurs (VS_LINES+V_BACK)·L ticks after VSYNC entry.
- Frame length = (VS_LINES+V_BACK+V_ACTIVE+V_FRONT)·L ticks.

## Structure

- Package `dvp_pkg`: FSM state enum (IDLE, VSYNC, VBACK, ACTIVE, VFRONT), the eight RGB565 bar constants, and pattern-select encodings.
- Sub-module `dvp_pclk_gen`: divider producing `Pclk` and the tick strobe, with a hold/clear input driven by `PWDN`/`rst`.
- The top level contains the FSM, the column/line counters and the pattern mux.

## Test plan

All scenarios use overrides H_ACTIVE=8, V_ACTIVE=4, H_BLANK=4, VS_LINES=1, V_BACK=1, V_FRONT=1, PCLK_DIV=2 unless noted.

- Reset: `rst`=1 for 5 cycles, `PWDN`=0 → all outputs 0 throughout. After release, the first `Pclk` rise occurs at cycle 2, and `frame_start` pulses once with `Vsyn`=1.
- Frame geometry: count ticks from `frame_start` → `Vsyn` high for 20 ticks, `Href` rises at tick 40, four `Href` pulses of 16 ticks each separated by 4 low ticks, next `frame_start` at tick 140, `frame_cnt`=1.
- Colour bars: `pattern_sel`=0, sample `data` on `Pclk` rises during line 0 → FF,FF,FF,E0,07,FF,07,E0,F8,1F,F8,00,00,1F,00,00.
- Ramp: `pattern_sel`=1 → line 2 bytes are 2..17. Toggling `pattern_sel` mid-frame has no effect until the next `frame_start`.
- Power-down mid-line: assert `PWDN` during the 3rd `Href` pulse → next cycle all outputs 0 and `frame_cnt` unchanged. After release, a full VSYNC follows before the next `Href`.
- Divider edge: PCLK_DIV=1 → Pclk period is 2 `clk` cycles, and `data` is stable for ≥1 cycle on either side of each `Pclk` rise.

Source files
------------

// File: rtl/dvp_pkg.sv
// Shared types and constants for the DVP test-pattern source.
// FSM states, RGB565 bar palette and pattern-select encodings.
package dvp_pkg;

  typedef enum logic [2:0] {
    IDLE,
    VSYNC,
    VBACK,
    ACTIVE,
    VFRONT
  } state_t;

  localparam logic PAT_BARS = 1'b0;
  localparam logic PAT_RAMP = 1'b1;

  localparam logic [15:0] BAR_WHITE   = 16'hFFFF;
  localparam logic [15:0] BAR_YELLOW  = 16'hFFE0;
  localparam logic [15:0] BAR_CYAN    = 16'h07FF;
  localparam logic [15:0] BAR_GREEN   = 16'h07E0;
  localparam logic [15:0] BAR_MAGENTA = 16'hF81F;
  localparam logic [15:0] BAR_RED     = 16'hF800;
  localparam logic [15:0] BAR_BLUE    = 16'h001F;
  localparam logic [15:0] BAR_BLACK   = 16'h0000;

  function automatic logic [15:0] bar_rgb(input logic [2:0] idx);
    case (idx)
      3'd0:    return BAR_WHITE;
      3'd1:    return BAR_YELLOW;
      3'd2:    return BAR_CYAN;
      3'd3:    return BAR_GREEN;
      3'd4:    return BAR_MAGENTA;
      3'd5:    return BAR_RED;
      3'd6:    return BAR_BLUE;
      default: return BAR_BLACK;
    endcase
  endfunction

endpackage

// File: rtl/dvp_pclk_gen.sv
// Pixel clock divider: toggles pclk every PCLK_DIV clk cycles and
// flags the falling-edge cycle as the protocol tick.
module dvp_pclk_gen #(
  parameter int PCLK_DIV = 2
) (
  input  logic clk,
  input  logic hold,
  output logic pclk,
  output logic tick
);

  localparam int DW = (PCLK_DIV > 1) ? $clog2(PCLK_DIV) : 1;

  logic [DW-1:0] div;
  logic          term;

  assign term = (div == DW'(PCLK_DIV - 1));
  assign tick = term & pclk & ~hold;

  always_ff @(posedge clk) begin
    if (hold) begin
      div  <= '0;
      pclk <= 1'b0;
    end else if (term) begin
      div  <= '0;
      pclk <= ~pclk;
    end else begin
      div <= div + 1'b1;
    end
  end

endmodule

// File: rtl/dvp_frame_source.sv
// OV7670-style DVP source producing RGB565 colour bars or a ramp
// with programmable blanking; all protocol state moves on Pclk falls.
module dvp_frame_source
  import dvp_pkg::*;
#(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int H_BLANK  = 144,
  parameter int VS_LINES = 3,
  parameter int V_BACK   = 17,
  parameter int V_FRONT  = 10,
  parameter int PCLK_DIV = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        PWDN,
  input  logic        pattern_sel,
  output logic        Pclk,
  output logic        Vsyn,
  output logic        Href,
  output logic [7:0]  data,
  output logic        frame_start,
  output logic [15:0] frame_cnt
);

  localparam int L     = 2 * H_ACTIVE + H_BLANK;
  localparam int HA2   = 2 * H_ACTIVE;
  localparam int BAR_W = H_ACTIVE / 8;
  localparam int M1    = (VS_LINES > V_BACK) ? VS_LINES : V_BACK;
  localparam int M2    = (V_ACTIVE > V_FRONT) ? V_ACTIVE : V_FRONT;
  localparam int VMAX  = (M1 > M2) ? M1 : M2;
  localparam int CW    = $clog2(L);
  localparam int LW    = $clog2(VMAX + 1);

  state_t        state, nstate;
  logic [CW-1:0] col, ncol;
  logic [LW-1:0] line, nline;
  logic          pat, npat;
  logic          tick, eol, entering, nhref;
  logic [2:0]    bar;
  logic [15:0]   rgb;
  logic [7:0]    ndata;

  dvp_pclk_gen #(.PCLK_DIV(PCLK_DIV)) u_pclk (
    .clk  (clk),
    .hold (rst | PWDN),
    .pclk (Pclk),
    .tick (tick)
  );

  always_comb begin
    eol    = (col == CW'(L - 1));
    ncol   = eol ? '0 : col + 1'b1;
    nline  = eol ? line + 1'b1 : line;
    nstate = state;
    unique case (state)
      IDLE: begin
        nstate = VSYNC;
        ncol   = '0;
        nline  = '0;
      end
      VSYNC: if (eol && line == LW'(VS_LINES - 1)) begin
        nstate = VBACK;
        nline  = '0;
      end
      VBACK: if (eol && line == LW'(V_BACK - 1)) begin
        nstate = ACTIVE;
        nline  = '0;
      end
      ACTIVE: if (eol && line == LW'(V_ACTIVE - 1)) begin
        nstate = VFRONT;
        nline  = '0;
      end
      VFRONT: if (eol && line == LW'(V_FRONT - 1)) begin
        nstate = VSYNC;
        nline  = '0;
      end
      default: nstate = IDLE;
    endcase
    entering = (nstate == VSYNC) && (state != VSYNC);
    npat     = entering ? pattern_sel : pat;
    nhref    = (nstate == ACTIVE) && (ncol < CW'(HA2));
    // Outputs are precomputed from the next column so they land on the tick.
    bar   = 3'(ncol[CW-1:1] / (CW-1)'(BAR_W));
    rgb   = bar_rgb(bar);
    ndata = '0;
    if (nhref) begin
      if (npat == PAT_RAMP)
        ndata = 8'(32'(ncol) + 32'(nline));
      else
        ndata = ncol[0] ? rgb[7:0] : rgb[15:8];
    end
  end

  always_ff @(posedge clk) begin
    if (rst || PWDN) begin
      state       <= IDLE;
      col         <= '0;
      line        <= '0;
      pat         <= 1'b0;
      Vsyn        <= 1'b0;
      Href        <= 1'b0;
      data        <= '0;
      frame_start <= 1'b0;
      if (rst)
        frame_cnt <= '0;
    end else begin
      frame_start <= 1'b0;
      if (tick) begin
        state       <= nstate;
        col         <= ncol;
        line        <= nline;
        pat         <= npat;
        Vsyn        <= (nstate == VSYNC);
        Href        <= nhref;
        data        <= ndata;
        frame_start <= entering;
        if (entering && state == VFRONT)
          frame_cnt <= frame_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_dvp_frame_source.sv
// Directed bench for dvp_frame_source: reset, geometry, patterns,
// power-down abort and the PCLK_DIV=1 divider corner.
module tb_dvp_frame_source;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        pwdn = 1'b0;
  logic        pwdn1 = 1'b0;
  logic        pattern_sel = 1'b0;

  logic        pclk, vsyn, href, frame_start;
  logic [7:0]  data;
  logic [15:0] frame_cnt;

  logic        pclk1, vsyn1, href1, fs1;
  logic [7:0]  data1;
  logic [15:0] fc1;

  int n_asrt = 0;
  int n_fail = 0;
  int t = 0;

  logic [7:0] bars [16] = '{8'hFF, 8'hFF, 8'hFF, 8'hE0,
                            8'h07, 8'hFF, 8'h07, 8'hE0,
                            8'hF8, 8'h1F, 8'hF8, 8'h00,
                            8'h00, 8'h1F, 8'h00, 8'h00};

  always #5 clk = ~clk;

  dvp_frame_source #(
    .H_ACTIVE(8), .V_ACTIVE(4), .H_BLANK(4), .VS_LINES(1),
    .V_BACK(1), .V_FRONT(1), .PCLK_DIV(2)
  ) dut (
    .clk(clk), .rst(rst), .PWDN(pwdn), .pattern_sel(pattern_sel),
    .Pclk(pclk), .Vsyn(vsyn), .Href(href), .data(data),
    .frame_start(frame_start), .frame_cnt(frame_cnt)
  );

  dvp_frame_source #(
    .H_ACTIVE(8), .V_ACTIVE(4), .H_BLANK(4), .VS_LINES(1),
    .V_BACK(1), .V_FRONT(1), .PCLK_DIV(1)
  ) dut1 (
    .clk(clk), .rst(rst), .PWDN(pwdn1), .pattern_sel(pattern_sel),
    .Pclk(pclk1), .Vsyn(vsyn1), .Href(href1), .data(data1),
    .frame_start(fs1), .frame_cnt(fc1)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic to_t(input int target);
    repeat ((target - t) * 4) @(negedge clk);
    t = target;
  endtask

  // Called right after rst/PWDN drop; leaves the bench on tick 1.
  task automatic sync_start(input logic [15:0] fc);
    @(negedge clk) chk("pclk_c1", pclk, 0);
    @(negedge clk) chk("pclk_rise_c2", pclk, 1);
    @(negedge clk) chk("vsyn_pre", vsyn, 0);
    @(negedge clk);
    chk("vsyn_start", vsyn, 1);
    chk("fs_pulse", frame_start, 1);
    chk("fc_start", frame_cnt, fc);
    @(negedge clk) chk("fs_one_clk", frame_start, 0);
    repeat (3) @(negedge clk);
    t = 1;
  endtask

  initial begin
    logic pp, pd_seen;
    logic [7:0] pd;

    repeat (5) @(negedge clk)
      chk("rst_outs", {pclk, vsyn, href, data, frame_start, frame_cnt}, 0);
    rst = 1'b0;
    sync_start(16'd0);

    to_t(19); chk("vsyn_t19", vsyn, 1);
    to_t(20); chk("vsyn_t20", vsyn, 0);
    to_t(39); chk("href_t39", href, 0);
    for (int i = 0; i < 16; i++) begin
      to_t(40 + i);
      chk("bars_href", href, 1);
      chk("bars_data", data, bars[i]);
    end
    to_t(56); chk("hblank_href", href, 0); chk("hblank_data", data, 0);
    to_t(60); chk("line1_href", href, 1);

    to_t(61); pattern_sel = 1'b1;
    to_t(80); chk("latch_l2c0", data, 8'hFF);
    to_t(83); chk("latch_l2c3", data, 8'hE0);
    to_t(120); chk("vfront_href", href, 0);
    to_t(139); chk("fc_t139", frame_cnt, 0); chk("vsyn_t139", vsyn, 0);
    to_t(140);
    chk("vsyn_t140", vsyn, 1);
    chk("fs_t140", frame_start, 1);
    chk("fc_t140", frame_cnt, 1);

    to_t(180); chk("ramp_l0c0", data, 0); chk("ramp_href", href, 1);
    to_t(181); chk("ramp_l0c1", data, 1);
    for (int i = 0; i < 16; i++) begin
      to_t(220 + i);
      chk("ramp_l2", data, 2 + i);
    end

    to_t(280); chk("fc_t280", frame_cnt, 2);
    to_t(365); chk("pwdn_pre_href", href, 1);
    pwdn = 1'b1;
    @(negedge clk);
    chk("pwdn_outs", {pclk, vsyn, href, data, frame_start}, 0);
    chk("pwdn_fc", frame_cnt, 2);
    repeat (6) @(negedge clk);
    chk("pwdn_hold", {pclk, vsyn, href, data}, 0);
    pwdn = 1'b0;
    sync_start(16'd2);
    to_t(19); chk("rv_vsyn", vsyn, 1); chk("rv_href19", href, 0);
    to_t(39); chk("rv_href39", href, 0); chk("rv_vsyn39", vsyn, 0);
    to_t(40); chk("rv_href40", href, 1);

    pp = pclk1;
    pd = data1;
    pd_seen = 1'b0;
    repeat (300) begin
      @(negedge clk);
      chk("div1_toggle", pclk1, !pp);
      if (!pp && pclk1)
        chk("div1_stable_rise", data1, pd);
      if (data1 != 8'd0)
        pd_seen = 1'b1;
      pp = pclk1;
      pd = data1;
    end
    chk("div1_active_seen", pd_seen, 1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_asrt, n_fail);
    $finish;
  end

endmodule
